// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared types and constants for the reorder buffer slice.
//               Tag width, "no producer" tag, entry-type encodings and the
//               word / register-index types used by the core.
// Revision    : 1.0  initial release
// ============================================================================
package rob_pkg;

    // Tag width; the buffer has (1 << ROB_IDX_LN) slots, slot 0 reserved.
    localparam int ROB_IDX_LN = 3;
    typedef logic [ROB_IDX_LN-1:0] ROB_IDX_TP;

    // Tag 0 is never allocated and means "value already architectural".
    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;

    // Entry-type encodings carried on id_type.
    localparam logic [1:0] ROB_TYPE_REG  = 2'd0;
    localparam logic [1:0] ROB_TYPE_BR   = 2'd1;
    localparam logic [1:0] ROB_TYPE_ST   = 2'd2;
    localparam logic [1:0] ROB_TYPE_JALR = 2'd3;

    localparam int REG_IDX_LN = 5;
    typedef logic [REG_IDX_LN-1:0] REG_IDX_TP;
    typedef logic [31:0]           WORD_TP;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_ptr_inc.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr_inc
// Description : Combinational head/tail pointer increment. Wraps from the
//               last slot back to 1 so that slot 0 is never visited.
// Ports       : i_ptr  current pointer (1..ROB_SIZE-1)
//               o_ptr  next pointer    (1..ROB_SIZE-1)
// Revision    : 1.0  initial release
// ============================================================================
module rob_ptr_inc #(
    parameter int ROB_BIT  = 3,
    parameter int ROB_SIZE = 1 << ROB_BIT
) (
    input  logic [ROB_BIT-1:0] i_ptr,
    output logic [ROB_BIT-1:0] o_ptr
);

    localparam logic [ROB_BIT-1:0] C_LAST = ROB_BIT'(ROB_SIZE - 1);
    localparam logic [ROB_BIT-1:0] C_ONE  = ROB_BIT'(1);

    assign o_ptr = (i_ptr == C_LAST) ? C_ONE : (i_ptr + C_ONE);

endmodule : rob_ptr_inc
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : Reorder buffer. Allocates a tag per issued instruction,
//               captures results from the common data bus, retires one
//               entry per cycle in program order and raises a rollback
//               pulse when a committed BR mispredicts or a JALR retires.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               rdy, rob_st              freeze inputs (rdy low / stall high)
//               id_full, id_tag          allocation status / next tag
//               id_ena..id_npc           issue interface
//               id_qry*/id_rdy*/id_qval* operand lookup (two ports)
//               cdb_*                    result broadcast
//               rob_wr_*                 registered register-file commit
//               rob_rb, rob_rb_pc        registered rollback pulse / PC
//               rob_st_commit/_idx       registered store-retire pulse / tag
// Config      : ROB_CDB_BYPASS_EN - when defined, the lookup ports forward
//               a same-cycle CDB broadcast combinationally.
// Revision    : 1.0  initial release
// ============================================================================
module rob
    import rob_pkg::*;
#(
    parameter int ROB_BIT  = ROB_IDX_LN,
    parameter int ROB_SIZE = 1 << ROB_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rob_st,
    output logic                  id_full,
    output logic [ROB_BIT-1:0]    id_tag,
    input  logic                  id_ena,
    input  logic [1:0]            id_type,
    input  logic [REG_IDX_LN-1:0] id_rd,
    input  logic                  id_pred,
    input  logic [31:0]           id_npc,
    input  logic [ROB_BIT-1:0]    id_qry1,
    input  logic [ROB_BIT-1:0]    id_qry2,
    output logic                  id_rdy1,
    output logic                  id_rdy2,
    output logic [31:0]           id_qval1,
    output logic [31:0]           id_qval2,
    input  logic                  cdb_ena,
    input  logic [ROB_BIT-1:0]    cdb_tag,
    input  logic [31:0]           cdb_val,
    input  logic                  cdb_taken,
    input  logic [31:0]           cdb_tgt,
    output logic                  rob_wr_ena,
    output logic [REG_IDX_LN-1:0] rob_wr_rd,
    output logic [31:0]           rob_wr_val,
    output logic [ROB_BIT-1:0]    rob_wr_idx,
    output logic                  rob_rb,
    output logic [31:0]           rob_rb_pc,
    output logic                  rob_st_commit,
    output logic [ROB_BIT-1:0]    rob_st_idx
);

    localparam logic [ROB_BIT-1:0] C_LAST = ROB_BIT'(ROB_SIZE - 1);
    localparam logic [ROB_BIT-1:0] C_ONE  = ROB_BIT'(1);

    // ------------------------------------------------------------------
    // Per-slot state
    // ------------------------------------------------------------------
    logic                  r_busy  [ROB_SIZE];
    logic                  r_done  [ROB_SIZE];
    logic [1:0]            r_type  [ROB_SIZE];
    logic [REG_IDX_LN-1:0] r_rd    [ROB_SIZE];
    logic [31:0]           r_val   [ROB_SIZE];
    logic                  r_pred  [ROB_SIZE];
    logic [31:0]           r_npc   [ROB_SIZE];
    logic                  r_taken [ROB_SIZE];
    logic [31:0]           r_tgt   [ROB_SIZE];

    logic [ROB_BIT-1:0]    r_head;
    logic [ROB_BIT-1:0]    r_tail;
    logic [ROB_BIT-1:0]    r_count;

    // Registered commit-side outputs
    logic                  r_wr_ena;
    logic [REG_IDX_LN-1:0] r_wr_rd;
    logic [31:0]           r_wr_val;
    logic [ROB_BIT-1:0]    r_wr_idx;
    logic                  r_rb;
    logic [31:0]           r_rb_pc;
    logic                  r_st_commit;
    logic [ROB_BIT-1:0]    r_st_idx;

    // ------------------------------------------------------------------
    // Pointer increments
    // ------------------------------------------------------------------
    logic [ROB_BIT-1:0] w_head_inc;
    logic [ROB_BIT-1:0] w_tail_inc;

    rob_ptr_inc #(.ROB_BIT(ROB_BIT), .ROB_SIZE(ROB_SIZE)) u_head_inc (
        .i_ptr (r_head),
        .o_ptr (w_head_inc)
    );

    rob_ptr_inc #(.ROB_BIT(ROB_BIT), .ROB_SIZE(ROB_SIZE)) u_tail_inc (
        .i_ptr (r_tail),
        .o_ptr (w_tail_inc)
    );

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_freeze;
    logic       w_commit;
    logic [1:0] w_htype;
    logic       w_mispred;
    logic       w_rollback;
    logic       w_issue;
    logic       w_wb;
    logic       w_wr_fire;
    logic       w_st_fire;
    logic [31:0] w_rb_pc;

    assign id_full  = (r_count == C_LAST);
    assign id_tag   = r_tail;

    assign w_freeze = !rdy || rob_st;
    // Commit is decided purely from registered done, so a result written at
    // edge N retires at edge N+1.
    assign w_commit = !w_freeze && r_busy[r_head] && r_done[r_head];
    assign w_htype  = r_type[r_head];
    // JALR is treated as always mispredicted: fetch never follows it.
    assign w_mispred = ((w_htype == ROB_TYPE_BR) && (r_taken[r_head] != r_pred[r_head]))
                     || (w_htype == ROB_TYPE_JALR);
    assign w_rollback = w_commit && w_mispred;
    // A rollback squashes the whole window, so same-cycle issue and
    // writeback are dropped rather than landing in a cleared slot.
    assign w_issue  = !w_freeze && !w_rollback && id_ena && !id_full;
    assign w_wb     = !w_freeze && !w_rollback && cdb_ena && (cdb_tag != '0) && r_busy[cdb_tag];
    assign w_wr_fire = w_commit
                     && ((w_htype == ROB_TYPE_REG) || (w_htype == ROB_TYPE_JALR))
                     && (r_rd[r_head] != '0);
    assign w_st_fire = w_commit && (w_htype == ROB_TYPE_ST);
    assign w_rb_pc   = ((w_htype == ROB_TYPE_JALR) || r_taken[r_head]) ? r_tgt[r_head]
                                                                      : r_npc[r_head];

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_done[i]  <= 1'b0;
                r_type[i]  <= '0;
                r_rd[i]    <= '0;
                r_val[i]   <= '0;
                r_pred[i]  <= 1'b0;
                r_npc[i]   <= '0;
                r_taken[i] <= 1'b0;
                r_tgt[i]   <= '0;
            end
            r_head      <= C_ONE;
            r_tail      <= C_ONE;
            r_count     <= '0;
            r_wr_ena    <= 1'b0;
            r_wr_rd     <= '0;
            r_wr_val    <= '0;
            r_wr_idx    <= '0;
            r_rb        <= 1'b0;
            r_rb_pc     <= '0;
            r_st_commit <= 1'b0;
            r_st_idx    <= '0;
        end else if (w_freeze) begin
            r_wr_ena    <= 1'b0;
            r_rb        <= 1'b0;
            r_st_commit <= 1'b0;
        end else begin
            r_wr_ena    <= w_wr_fire;
            r_rb        <= w_rollback;
            r_st_commit <= w_st_fire;

            if (w_wr_fire) begin
                r_wr_rd  <= r_rd[r_head];
                r_wr_val <= r_val[r_head];
                r_wr_idx <= r_head;
            end
            if (w_rollback) begin
                r_rb_pc <= w_rb_pc;
            end
            if (w_st_fire) begin
                r_st_idx <= r_head;
            end

            if (w_wb) begin
                r_done[cdb_tag]  <= 1'b1;
                r_val[cdb_tag]   <= cdb_val;
                r_taken[cdb_tag] <= cdb_taken;
                r_tgt[cdb_tag]   <= cdb_tgt;
            end

            if (w_issue) begin
                r_busy[r_tail] <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_type[r_tail] <= id_type;
                r_rd[r_tail]   <= id_rd;
                r_pred[r_tail] <= id_pred;
                r_npc[r_tail]  <= id_npc;
                r_tail         <= w_tail_inc;
            end

            if (w_rollback) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    r_busy[i] <= 1'b0;
                end
                r_head  <= C_ONE;
                r_tail  <= C_ONE;
                r_count <= '0;
            end else begin
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= w_head_inc;
                end
                if (w_issue && !w_commit) begin
                    r_count <= r_count + C_ONE;
                end else if (!w_issue && w_commit) begin
                    r_count <= r_count - C_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand lookup
    // ------------------------------------------------------------------
    always_comb begin
        id_rdy1  = 1'b1;
        id_qval1 = '0;
        if (id_qry1 != '0) begin
            id_rdy1  = r_done[id_qry1];
            id_qval1 = r_val[id_qry1];
        end
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_ena && (cdb_tag != '0) && (cdb_tag == id_qry1)) begin
            id_rdy1  = 1'b1;
            id_qval1 = cdb_val;
        end
`endif
    end

    always_comb begin
        id_rdy2  = 1'b1;
        id_qval2 = '0;
        if (id_qry2 != '0) begin
            id_rdy2  = r_done[id_qry2];
            id_qval2 = r_val[id_qry2];
        end
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_ena && (cdb_tag != '0) && (cdb_tag == id_qry2)) begin
            id_rdy2  = 1'b1;
            id_qval2 = cdb_val;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rob_wr_ena    = r_wr_ena;
    assign rob_wr_rd     = r_wr_rd;
    assign rob_wr_val    = r_wr_val;
    assign rob_wr_idx    = r_wr_idx;
    assign rob_rb        = r_rb;
    assign rob_rb_pc     = r_rb_pc;
    assign rob_st_commit = r_st_commit;
    assign rob_st_idx    = r_st_idx;

endmodule : rob
`default_nettype wire
